// File: rtl/syzygy_dac_pkg.sv
// Shared types and constants for the SYZYGY DAC SPI arbiter slice.
package syzygy_dac_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  localparam logic REQ_CTRL = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/syzygy_dac_rr_arb.sv
// Two-way round-robin grant; the last-grant pointer resets to the host so the
// init controller wins the first contention.
module syzygy_dac_rr_arb
  import syzygy_dac_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt_id
);

  logic last_q;

  always_comb begin
    gnt_id = REQ_HOST;
    if (req0 && req1) begin
      gnt_id = ~last_q;
    end else if (req0) begin
      gnt_id = REQ_CTRL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_HOST;
    end else if (take) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/syzygy_dac_spi_arbiter.sv
// Arbitrates two DAC register requesters onto one SPI engine command port.
// Optional spi_done watchdog is built only when SPI_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no transaction; grant and latch command when any req is high
// ISSUE | one-cycle spi_send strobe
// WAIT  | waiting for spi_done (or watchdog expiry)
// DONE  | one-cycle done pulse to the granted requester
module syzygy_dac_spi_arbiter
  import syzygy_dac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r0_reg,
  input  logic [ADDR_W-1:0] r1_reg,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r0_rw,
  input  logic              r1_rw,
  output logic              r0_done,
  output logic              r1_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] spi_reg,
  output logic [DATA_W-1:0] spi_data_in,
  output logic              spi_rw,
  output logic              spi_send,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_data_out,
  output logic              busy,
  output logic              timeout_err
);

  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 16..65535");
  end

  arb_state_t state, state_nxt;
  logic       gnt_id;
  logic       gnt_id_q;
  logic       grant_take;
  logic       tmo_hit;

  syzygy_dac_rr_arb u_rr_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (r0_req),
    .req1   (r1_req),
    .take   (grant_take),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_take = 1'b0;
    spi_send   = 1'b0;
    r0_done    = 1'b0;
    r1_done    = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant_take = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        spi_send  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (spi_done || tmo_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        r0_done   = (gnt_id_q == REQ_CTRL);
        r1_done   = (gnt_id_q == REQ_HOST);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Command fields stay latched after the transaction until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_id_q    <= REQ_CTRL;
      spi_reg     <= '0;
      spi_data_in <= '0;
      spi_rw      <= 1'b0;
      rdata       <= '0;
    end else begin
      if (grant_take) begin
        gnt_id_q <= gnt_id;
        if (gnt_id == REQ_CTRL) begin
          spi_reg     <= r0_reg;
          spi_data_in <= r0_wdata;
          spi_rw      <= r0_rw;
        end else begin
          spi_reg     <= r1_reg;
          spi_data_in <= r1_wdata;
          spi_rw      <= r1_rw;
        end
      end
      if (state == WAIT) begin
        if (spi_done) begin
          rdata <= spi_data_out;
        end else if (tmo_hit) begin
          rdata <= 8'hFF;
        end
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_err_q;

  // Down-counter loaded while issuing; terminal count on the WAIT cycle
  // TIMEOUT_CYCLES after entry, so done lands one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tmo_cnt <= 16'(TIMEOUT_CYCLES);
      end else if (state == WAIT && tmo_cnt != 16'd0) begin
        tmo_cnt <= tmo_cnt - 16'd1;
      end
      if (tmo_hit && !spi_done) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign tmo_hit     = (state == WAIT) && (tmo_cnt == 16'd0);
  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_syzygy_dac_spi_arbiter.sv
// Scoreboard bench for syzygy_dac_spi_arbiter; timeout scenario runs only
// when SPI_ARB_TIMEOUT_EN is defined.
module tb_syzygy_dac_spi_arbiter;
  import syzygy_dac_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       r0_req = 1'b0, r1_req = 1'b0;
  logic [5:0] r0_reg = '0, r1_reg = '0;
  logic [7:0] r0_wdata = '0, r1_wdata = '0;
  logic       r0_rw = 1'b0, r1_rw = 1'b0;
  logic       r0_done, r1_done;
  logic [7:0] rdata;
  logic [5:0] spi_reg;
  logic [7:0] spi_data_in;
  logic       spi_rw, spi_send;
  logic       spi_done = 1'b0;
  logic [7:0] spi_data_out = '0;
  logic       busy, timeout_err;

  typedef struct packed { logic [5:0] rg; logic [7:0] wd; logic rw; } cmd_t;
  typedef struct packed { logic id; logic [7:0] rd; } cpl_t;

  cmd_t cmd_q[$];
  cpl_t cpl_q[$];

  int         total = 0;
  int         bad = 0;
  int         send_cnt = 0;
  int         idle_cnt = 0;
  int         spi_lat = 10;
  int         spi_cnt = -1;
  logic [7:0] spi_resp = '0;
  logic       inject_done = 1'b0;
  logic       model_last = 1'b1;

  syzygy_dac_spi_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .r0_req       (r0_req),
    .r1_req       (r1_req),
    .r0_reg       (r0_reg),
    .r1_reg       (r1_reg),
    .r0_wdata     (r0_wdata),
    .r1_wdata     (r1_wdata),
    .r0_rw        (r0_rw),
    .r1_rw        (r1_rw),
    .r0_done      (r0_done),
    .r1_done      (r1_done),
    .rdata        (rdata),
    .spi_reg      (spi_reg),
    .spi_data_in  (spi_data_in),
    .spi_rw       (spi_rw),
    .spi_send     (spi_send),
    .spi_done     (spi_done),
    .spi_data_out (spi_data_out),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // SPI engine model: spi_done spi_lat cycles after spi_send (spi_lat 0 = never)
  task automatic spi_engine();
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (reset) begin
        spi_cnt = -1;
      end else begin
        if (!busy) idle_cnt++;
        if (inject_done) begin
          spi_done = 1'b1;
          spi_data_out = 8'h77;
          inject_done = 1'b0;
        end else if (spi_cnt == 0) begin
          spi_done = 1'b1;
          spi_data_out = spi_resp;
          spi_cnt = -1;
        end else if (spi_cnt > 0) begin
          spi_cnt--;
        end
        if (spi_send) begin
          send_cnt++;
          if (spi_lat > 0) spi_cnt = spi_lat - 1;
        end
      end
    end
  endtask

  function automatic logic model_grant(input logic q0, input logic q1);
    if (q0 && q1) return ~model_last;
    return q0 ? REQ_CTRL : REQ_HOST;
  endfunction

  task automatic wait_send(input int budget, output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!spi_send && k < budget);
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!(r0_done || r1_done) && k < budget);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, spi_send, r0_done, r1_done, timeout_err, spi_rw} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {busy, spi_send, r0_done, r1_done, timeout_err, spi_rw});
    end
    total++;
    if (spi_reg !== 6'h00) begin bad++; $display("FAIL reset_spi_reg: got %h want 00", spi_reg); end
    total++;
    if (spi_data_in !== 8'h00) begin bad++; $display("FAIL reset_spi_data_in: got %h want 00", spi_data_in); end
    total++;
    if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int k; int s0; logic id; cmd_t c; cpl_t e;
    spi_lat = 10; spi_resp = 8'h3C;
    s0 = send_cnt;
    r0_reg = 6'h02; r0_wdata = 8'h20; r0_rw = 1'b0; r0_req = 1'b1;
    id = model_grant(1'b1, 1'b0); model_last = id;
    cmd_q.push_back('{rg: 6'h02, wd: 8'h20, rw: 1'b0});
    cpl_q.push_back('{id: id, rd: 8'h3C});
    wait_send(20, k);
    total++;
    if (k != 1) begin bad++; $display("FAIL single_send_latency: got %0d want 1", k); end
    c = cmd_q.pop_front();
    total++;
    if ({spi_reg, spi_data_in, spi_rw} !== c) begin
      bad++; $display("FAIL single_cmd: got %h/%h/%b want %h/%h/%b", spi_reg, spi_data_in, spi_rw, c.rg, c.wd, c.rw);
    end
    wait_done(40, k);
    total++;
    if (k != spi_lat + 1) begin bad++; $display("FAIL single_done_latency: got %0d want %0d", k, spi_lat + 1); end
    e = cpl_q.pop_front();
    total++;
    if ({r0_done, r1_done} !== (e.id ? 2'b01 : 2'b10)) begin
      bad++; $display("FAIL single_done_id: got %b%b want id %0d", r0_done, r1_done, e.id);
    end
    total++;
    if (rdata !== e.rd) begin bad++; $display("FAIL single_write_rdata: got %h want %h", rdata, e.rd); end
    r0_req = 1'b0;
    @(negedge clk);
    total++;
    if ({r0_done, r1_done, busy} !== 3'b000) begin
      bad++; $display("FAIL single_after_done: got %b want 000", {r0_done, r1_done, busy});
    end
    repeat (3) @(negedge clk);
    total++;
    if (send_cnt - s0 != 1) begin bad++; $display("FAIL single_send_count: got %0d want 1", send_cnt - s0); end
  endtask

  task automatic test_read();
    int k; logic id; cmd_t c; cpl_t e;
    spi_lat = 4; spi_resp = 8'hA5;
    r1_reg = 6'h1F; r1_wdata = 8'h5A; r1_rw = 1'b1; r1_req = 1'b1;
    id = model_grant(1'b0, 1'b1); model_last = id;
    cmd_q.push_back('{rg: 6'h1F, wd: 8'h5A, rw: 1'b1});
    cpl_q.push_back('{id: id, rd: 8'hA5});
    wait_send(20, k);
    c = cmd_q.pop_front();
    total++;
    if (k != 1 || {spi_reg, spi_data_in, spi_rw} !== c) begin
      bad++; $display("FAIL read_cmd: got lat %0d %h/%h/%b want lat 1 %h/%h/%b", k, spi_reg, spi_data_in, spi_rw, c.rg, c.wd, c.rw);
    end
    wait_done(40, k);
    e = cpl_q.pop_front();
    total++;
    if (k != spi_lat + 1) begin bad++; $display("FAIL read_done_latency: got %0d want %0d", k, spi_lat + 1); end
    total++;
    if ({r0_done, r1_done} !== (e.id ? 2'b01 : 2'b10)) begin
      bad++; $display("FAIL read_done_id: got %b%b want id %0d", r0_done, r1_done, e.id);
    end
    total++;
    if (rdata !== e.rd) begin bad++; $display("FAIL read_rdata: got %h want %h", rdata, e.rd); end
    r1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray_done();
    int hits;
    hits = 0;
    inject_done = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (r0_done || r1_done || busy) hits++;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL stray_done_activity: got %0d cycles want 0", hits); end
    total++;
    if (rdata !== 8'hA5) begin bad++; $display("FAIL stray_done_rdata: got %h want a5", rdata); end
  endtask

  task automatic test_contention();
    int k; int idle0; logic id; cmd_t c; cpl_t e;
    spi_lat = 3;
    idle0 = 0;
    r0_reg = 6'h05; r0_wdata = 8'h11; r0_rw = 1'b0;
    r1_reg = 6'h2A; r1_wdata = 8'h22; r1_rw = 1'b1;
    r0_req = 1'b1; r1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = model_grant(1'b1, 1'b1); model_last = id;
      spi_resp = 8'h40 + 8'(i);
      if (id == REQ_CTRL) cmd_q.push_back('{rg: 6'h05, wd: 8'h11, rw: 1'b0});
      else                cmd_q.push_back('{rg: 6'h2A, wd: 8'h22, rw: 1'b1});
      cpl_q.push_back('{id: id, rd: 8'h40 + 8'(i)});
      wait_send(20, k);
      if (i == 0) idle0 = idle_cnt;
      c = cmd_q.pop_front();
      total++;
      if (k != (i == 0 ? 1 : 2)) begin bad++; $display("FAIL cont_send_latency[%0d]: got %0d want %0d", i, k, (i == 0 ? 1 : 2)); end
      total++;
      if ({spi_reg, spi_data_in, spi_rw} !== c) begin
        bad++; $display("FAIL cont_cmd[%0d]: got %h/%h/%b want %h/%h/%b", i, spi_reg, spi_data_in, spi_rw, c.rg, c.wd, c.rw);
      end
      wait_done(40, k);
      e = cpl_q.pop_front();
      total++;
      if ({r0_done, r1_done} !== (e.id ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL cont_grant_order[%0d]: got %b%b want id %0d", i, r0_done, r1_done, e.id);
      end
      total++;
      if (rdata !== e.rd) begin bad++; $display("FAIL cont_rdata[%0d]: got %h want %h", i, rdata, e.rd); end
      if (i == 2) begin r0_req = 1'b0; r1_req = 1'b0; end
    end
    total++;
    if (idle_cnt - idle0 != 2) begin bad++; $display("FAIL cont_idle_gaps: got %0d want 2", idle_cnt - idle0); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL cont_final_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_req_drop();
    int k; logic id; cmd_t c; cpl_t e;
    spi_lat = 6; spi_resp = 8'h9C;
    r1_reg = 6'h0B; r1_wdata = 8'hC3; r1_rw = 1'b0; r1_req = 1'b1;
    id = model_grant(1'b0, 1'b1); model_last = id;
    cmd_q.push_back('{rg: 6'h0B, wd: 8'hC3, rw: 1'b0});
    cpl_q.push_back('{id: id, rd: 8'h9C});
    wait_send(20, k);
    c = cmd_q.pop_front();
    r1_req = 1'b0;
    total++;
    if (k != 1 || {spi_reg, spi_data_in, spi_rw} !== c) begin
      bad++; $display("FAIL drop_cmd: got lat %0d %h/%h/%b want lat 1 %h/%h/%b", k, spi_reg, spi_data_in, spi_rw, c.rg, c.wd, c.rw);
    end
    wait_done(40, k);
    e = cpl_q.pop_front();
    total++;
    if (k != spi_lat + 1 || {r0_done, r1_done} !== (e.id ? 2'b01 : 2'b10)) begin
      bad++; $display("FAIL drop_done: got lat %0d %b%b want lat %0d id %0d", k, r0_done, r1_done, spi_lat + 1, e.id);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({spi_reg, spi_data_in, spi_rw} !== c || busy !== 1'b0) begin
      bad++; $display("FAIL drop_hold_fields: got %h/%h/%b busy %b want %h/%h/%b busy 0", spi_reg, spi_data_in, spi_rw, busy, c.rg, c.wd, c.rw);
    end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k; logic id; cpl_t e;
    spi_lat = 0;
    r0_reg = 6'h10; r0_wdata = 8'h00; r0_rw = 1'b1; r0_req = 1'b1;
    id = model_grant(1'b1, 1'b0); model_last = id;
    cpl_q.push_back('{id: id, rd: 8'hFF});
    wait_send(20, k);
    wait_done(60, k);
    e = cpl_q.pop_front();
    r0_req = 1'b0;
    total++;
    if (k != 18) begin bad++; $display("FAIL tmo_done_latency: got %0d want 18", k); end
    total++;
    if ({r0_done, r1_done} !== (e.id ? 2'b01 : 2'b10) || rdata !== e.rd) begin
      bad++; $display("FAIL tmo_done: got %b%b rdata %h want id %0d rdata %h", r0_done, r1_done, rdata, e.id, e.rd);
    end
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err_set: got %b want 1", timeout_err); end
    spi_lat = 5; spi_resp = 8'h12;
    r1_reg = 6'h03; r1_rw = 1'b1; r1_req = 1'b1;
    id = model_grant(1'b0, 1'b1); model_last = id;
    cpl_q.push_back('{id: id, rd: 8'h12});
    wait_send(20, k);
    wait_done(40, k);
    e = cpl_q.pop_front();
    r1_req = 1'b0;
    total++;
    if (k != 6 || rdata !== e.rd) begin
      bad++; $display("FAIL tmo_good_after: got lat %0d rdata %h want lat 6 rdata %h", k, rdata, e.rd);
    end
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky: got %b want 1", timeout_err); end
  endtask
`endif

  task automatic test_reset_mid();
    int k; int hits;
    spi_lat = 0;
    r1_reg = 6'h33; r1_wdata = 8'h44; r1_rw = 1'b1; r1_req = 1'b1;
    wait_send(20, k);
    repeat (3) @(negedge clk);
    reset = 1'b1; r1_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    inject_done = 1'b1;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (r0_done || r1_done || busy || spi_send) hits++;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL rstmid_activity: got %0d cycles want 0", hits); end
    total++;
    if ({spi_reg, spi_data_in, spi_rw} !== 15'h0) begin
      bad++; $display("FAIL rstmid_fields: got %h/%h/%b want 00/00/0", spi_reg, spi_data_in, spi_rw);
    end
    total++;
    if (rdata !== 8'h00 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL rstmid_rdata_err: got %h/%b want 00/0", rdata, timeout_err);
    end
  endtask

  initial begin
    fork
      spi_engine();
      begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000ns");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_single();
    test_read();
    test_stray_done();
    test_contention();
    test_req_drop();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
